// File: rtl/lsl8_iter.sv
// Registered 8-bit logical-shift-left / rotate-left unit that advances at most
// three bit positions per clock, with a start/busy/done handshake.
module lsl8_iter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] d_in,
   input  logic [2:0] shamt,
   input  logic       mode,
   output logic [7:0] d_out,
   output logic       c_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] dbg_state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0] state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [2:0] rem_q, rem_d;
   logic       mode_q, mode_d;
   logic       c_q, c_d;

   logic [1:0] step;
   logic [7:0] stepped;
   logic       step_c;
   logic [2:0] rem_next;

   // One step per cycle is min(rem, 3); each bit picks from one of four sources.
   always_comb begin
      step     = (rem_q > 3'd3) ? 2'd3 : rem_q[1:0];
      stepped  = data_q;
      step_c   = c_q;
      rem_next = rem_q - {1'b0, step};
      case (step)
         2'd1: begin
            stepped = {data_q[6:0], mode_q ? data_q[7] : 1'b0};
            step_c  = data_q[7];
         end
         2'd2: begin
            stepped = {data_q[5:0], mode_q ? data_q[7:6] : 2'b00};
            step_c  = data_q[6];
         end
         2'd3: begin
            stepped = {data_q[4:0], mode_q ? data_q[7:5] : 3'b000};
            step_c  = data_q[5];
         end
         default: begin
            stepped = data_q;
            step_c  = c_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      mode_d  = mode_q;
      c_d     = c_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               data_d  = d_in;
               rem_d   = shamt;
               mode_d  = mode;
               c_d     = 1'b0;
               state_d = (shamt != 3'd0) ? S_SHIFT : S_DONE;
            end
         end
         S_SHIFT: begin
            data_d  = stepped;
            c_d     = step_c;
            rem_d   = rem_next;
            state_d = (rem_next == 3'd0) ? S_DONE : S_SHIFT;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         data_q  <= 8'h00;
         rem_q   <= 3'd0;
         mode_q  <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
         c_q     <= c_d;
      end
   end

   assign d_out       = data_q;
   assign c_out       = c_q;
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lsl8_iter.sv
// Bench for lsl8_iter: vector table, random ops against a closed-form model,
// and hand sequences for reset abort and start-while-busy.
module tb_lsl8_iter;

   localparam int W = 11;  // {d_out[7:0], c_out, steps[1:0]}

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [7:0] d_in;
   logic [2:0] shamt;
   logic       mode;
   logic [7:0] d_out;
   logic       c_out;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [7:0] d;
      logic [2:0] s;
      logic       m;
      logic [7:0] exp_d;
      logic       exp_c;
      logic [1:0] exp_k;
   } vec_t;

   vec_t vecs[10];

   lsl8_iter dut (
      .clk(clk), .reset_n(reset_n), .start(start), .d_in(d_in), .shamt(shamt),
      .mode(mode), .d_out(d_out), .c_out(c_out), .busy(busy), .done(done),
      .dbg_state_o(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Closed form: full shift/rotate at once; last bit out is original bit 8-s.
   function automatic logic [W-1:0] model(input logic [7:0] d, input logic [2:0] s, input logic m);
      logic [15:0] w;
      logic [7:0]  r;
      logic        c;
      int          k;
      w = {8'h00, d} << s;
      r = m ? (w[7:0] | w[15:8]) : w[7:0];
      c = (s == 3'd0) ? 1'b0 : d[8 - int'(s)];
      k = (int'(s) + 2) / 3;
      return {r, c, k[1:0]};
   endfunction

   // Start one op, count edges to done, compare against the scoreboard.
   task automatic run_op(input logic [7:0] d, input logic [2:0] s, input logic m,
                         input logic [W-1:0] exp, input logic chk_mid, input logic [7:0] mid);
      logic [W-1:0] e;
      int cnt;
      @(negedge clk);
      d_in = d; shamt = s; mode = m; start = 1'b1;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      start = 1'b0;
      d_in = ~d; shamt = s + 3'd3; mode = ~m;  // post-capture changes must not matter
      check("busy_after_start", busy, 1'b1);
      cnt = 0;
      while (!done && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
         if (chk_mid && cnt == 1) check("mid_step_d_out", d_out, mid);
      end
      e = exp_q.pop_front();
      if (!done) begin
         n_checks++; n_errors++;
         $display("FAIL done_timeout: got no done expected done within 8 cycles");
      end
      check("steps_to_done", cnt, e[1:0]);
      check("result_d_out", d_out, e[10:3]);
      check("result_c_out", c_out, e[2]);
      @(posedge clk); #1;
      check("done_one_cycle", done, 1'b0);
      check("busy_low_after_done", busy, 1'b0);
      check("result_hold", d_out, e[10:3]);
   endtask

   initial begin
      logic [7:0] rd;
      logic [2:0] rs;
      logic       rm;
      int         cnt;
      vecs[0] = '{8'h81, 3'd1, 1'b0, 8'h02, 1'b1, 2'd1};
      vecs[1] = '{8'hB5, 3'd7, 1'b0, 8'h80, 1'b0, 2'd3};
      vecs[2] = '{8'hB5, 3'd4, 1'b1, 8'h5B, 1'b1, 2'd2};
      vecs[3] = '{8'h3C, 3'd0, 1'b0, 8'h3C, 1'b0, 2'd0};
      vecs[4] = '{8'h3C, 3'd0, 1'b1, 8'h3C, 1'b0, 2'd0};
      vecs[5] = '{8'hFF, 3'd3, 1'b0, 8'hF8, 1'b1, 2'd1};
      vecs[6] = '{8'hFF, 3'd6, 1'b1, 8'hFF, 1'b1, 2'd2};
      vecs[7] = '{8'h01, 3'd7, 1'b1, 8'h80, 1'b0, 2'd3};
      vecs[8] = '{8'hC3, 3'd5, 1'b0, 8'h60, 1'b0, 2'd2};
      vecs[9] = '{8'h96, 3'd2, 1'b1, 8'h5A, 1'b0, 2'd1};

      reset_n = 1'b0; start = 1'b0; d_in = 8'h00; shamt = 3'd0; mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_d_out", d_out, 8'h00);
      check("reset_c_out", c_out, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      @(negedge clk); reset_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_op(vecs[i].d, vecs[i].s, vecs[i].m, {vecs[i].exp_d, vecs[i].exp_c, vecs[i].exp_k},
                (vecs[i].d == 8'hB5 && vecs[i].m), 8'hAD);

      for (int i = 0; i < 12; i++) begin
         rd = 8'($urandom_range(0, 255));
         rs = 3'($urandom_range(0, 7));
         rm = 1'($urandom_range(0, 1));
         run_op(rd, rs, rm, model(rd, rs, rm), 1'b0, 8'h00);
      end

      // Asynchronous reset in the middle of a 7-position shift.
      @(negedge clk);
      d_in = 8'hFF; shamt = 3'd7; mode = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #3;
      check("pre_abort_busy", busy, 1'b1);
      reset_n = 1'b0; #1;
      check("abort_d_out", d_out, 8'h00);
      check("abort_c_out", c_out, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      @(negedge clk); reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_after_abort_busy", busy, 1'b0);
      check("idle_after_abort_d_out", d_out, 8'h00);

      // start pulsed during SHIFT and during DONE is ignored; held start lands in IDLE.
      @(negedge clk);
      d_in = 8'hB5; shamt = 3'd7; mode = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      d_in = 8'h12; shamt = 3'd1; mode = 1'b1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      check("ignored_in_shift_busy", busy, 1'b1);
      cnt = 1;
      while (!done && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("hs_steps_to_done", cnt, 3);
      check("hs_first_d_out", d_out, 8'h80);
      check("hs_first_c_out", c_out, 1'b0);
      d_in = 8'h3C; shamt = 3'd2; mode = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("ignored_in_done_busy", busy, 1'b0);
      check("ignored_in_done_d_out", d_out, 8'h80);
      @(posedge clk); #1;
      start = 1'b0;
      check("held_start_busy", busy, 1'b1);
      check("held_start_capture", d_out, 8'h3C);
      cnt = 0;
      while (!done && cnt < 8) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("second_steps", cnt, 1);
      check("second_d_out", d_out, 8'hF0);
      check("second_c_out", c_out, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

endmodule
